// File: rtl/chord_note_sequencer.sv
// Song ROM walker feeding the chord voice engine: issues {note, duration} load
// strobes, holds on wait entries for a number of shared beats, flags end of song.
module chord_note_sequencer #(
    parameter int ADDR_W      = 7,
    parameter int ROM_LATENCY = 1
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              play_i,
    input  logic              song_start_i,
    input  logic              beat_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [15:0]       rom_data_i,
    output logic [5:0]        note_to_load_o,
    output logic [5:0]        duration_o,
    output logic              load_new_note_o,
    output logic              song_done_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_LOAD   = 3'd3,
        S_WAIT   = 3'd4,
        S_DONE   = 3'd5
    } state_e;

    localparam logic [ADDR_W-1:0] ADDR_MAX   = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [1:0]        FETCH_LAST = 2'(ROM_LATENCY - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [5:0]        note_q, note_d;
    logic [5:0]        dur_q, dur_d;
    logic              load_q, load_d;
    logic              done_q, done_d;
    logic [5:0]        wait_q, wait_d;
    logic [1:0]        fcnt_q, fcnt_d;
    logic              adv_s;

    // Next-state decode; song_start is applied last so it overrides any decision.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        note_d  = note_q;
        dur_d   = dur_q;
        load_d  = 1'b0;
        done_d  = done_q;
        wait_d  = wait_q;
        fcnt_d  = fcnt_q;
        adv_s   = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_IDLE;
            end
            S_FETCH: begin
                if (!play_i) begin
                    fcnt_d = fcnt_q;
                end else if (fcnt_q == FETCH_LAST) begin
                    fcnt_d  = 2'd0;
                    state_d = S_DECODE;
                end else begin
                    fcnt_d = fcnt_q + 2'd1;
                end
            end
            S_DECODE: begin
                if (rom_data_i == 16'h0000) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (!rom_data_i[15]) begin
                    if (rom_data_i[14:9] != 6'd0) begin
                        state_d = S_LOAD;
                        load_d  = 1'b1;
                        note_d  = rom_data_i[14:9];
                        dur_d   = rom_data_i[8:3];
                    end else begin
                        adv_s = 1'b1;
                    end
                end else if (rom_data_i[5:0] == 6'd0) begin
                    adv_s = 1'b1;
                end else begin
                    state_d = S_WAIT;
                    wait_d  = rom_data_i[5:0];
                end
            end
            S_LOAD: begin
                adv_s = 1'b1;
            end
            S_WAIT: begin
                // The beat that takes the counter to zero also releases the wait.
                if (play_i && beat_i) begin
                    wait_d = wait_q - 6'd1;
                    adv_s  = (wait_q == 6'd1);
                end else begin
                    wait_d = wait_q;
                end
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (adv_s) begin
            if (addr_q == ADDR_MAX) begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end else begin
                addr_d  = addr_q + ADDR_ONE;
                state_d = S_FETCH;
                fcnt_d  = 2'd0;
            end
        end else begin
            addr_d = addr_d;
        end

        if (song_start_i) begin
            state_d = S_FETCH;
            addr_d  = {ADDR_W{1'b0}};
            wait_d  = 6'd0;
            fcnt_d  = 2'd0;
            load_d  = 1'b0;
            done_d  = 1'b0;
        end else begin
            state_d = state_d;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= S_IDLE;
            addr_q  <= {ADDR_W{1'b0}};
            note_q  <= 6'd0;
            dur_q   <= 6'd0;
            load_q  <= 1'b0;
            done_q  <= 1'b0;
            wait_q  <= 6'd0;
            fcnt_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            note_q  <= note_d;
            dur_q   <= dur_d;
            load_q  <= load_d;
            done_q  <= done_d;
            wait_q  <= wait_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign rom_addr_o      = addr_q;
    assign note_to_load_o  = note_q;
    assign duration_o      = dur_q;
    assign load_new_note_o = load_q;
    assign song_done_o     = done_q;

endmodule
